// File: rtl/sys_array_result_streamer_if.sv
// Result stream interface: one matrix element per valid/ready handshake,
// tagged with its row/column index and a last-element marker.
interface sys_array_result_streamer_if #(
  parameter int DATA_WIDTH = 8,
  parameter int ARRAY_W_W  = 5,
  parameter int ARRAY_A_L  = 15,
  parameter int ROW_BITS   = (ARRAY_W_W > 1) ? $clog2(ARRAY_W_W) : 1,
  parameter int COL_BITS   = (ARRAY_A_L > 1) ? $clog2(ARRAY_A_L) : 1
);

  logic                    m_valid;
  logic                    m_ready;
  logic [2*DATA_WIDTH-1:0] m_data;
  logic [ROW_BITS-1:0]     m_row;
  logic [COL_BITS-1:0]     m_col;
  logic                    m_last;

  modport master (
    output m_valid,
    output m_data,
    output m_row,
    output m_col,
    output m_last,
    input  m_ready
  );

  modport slave (
    input  m_valid,
    input  m_data,
    input  m_row,
    input  m_col,
    input  m_last,
    output m_ready
  );

endinterface

// File: rtl/sys_array_result_streamer.sv
// Drain side of the systolic array fetcher. A rising edge on fetch_ready
// captures the whole result matrix into a shadow register; the shadow copy is
// then streamed out row-major, one element per handshake, so the fetcher is
// free to start its next computation while results drain.
module sys_array_result_streamer #(
  parameter int DATA_WIDTH = 8,
  parameter int ARRAY_W_W  = 5,
  parameter int ARRAY_A_L  = 15,
  parameter int ROW_BITS   = (ARRAY_W_W > 1) ? $clog2(ARRAY_W_W) : 1,
  parameter int COL_BITS   = (ARRAY_A_L > 1) ? $clog2(ARRAY_A_L) : 1
) (
  input  logic clk,
  input  logic reset_n,
  input  logic fetch_ready,
  input  logic [0:ARRAY_W_W-1][0:ARRAY_A_L-1][2*DATA_WIDTH-1:0] fetch_data,
  sys_array_result_streamer_if.master m_if,
  output logic busy,
  output logic done,
  output logic overrun,
  input  logic clr_overrun
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_STREAM = 2'd1,
    S_DONE   = 2'd2
  } state_t;

  localparam logic [ROW_BITS-1:0] ROW_ZERO = {ROW_BITS{1'b0}};
  localparam logic [COL_BITS-1:0] COL_ZERO = {COL_BITS{1'b0}};
  localparam logic [ROW_BITS-1:0] ROW_LAST = ROW_BITS'(ARRAY_W_W - 1);
  localparam logic [COL_BITS-1:0] COL_LAST = COL_BITS'(ARRAY_A_L - 1);
  // A 1x1 matrix makes the very first element also the last one.
  localparam logic SINGLE_ELEM = (ARRAY_W_W == 1) && (ARRAY_A_L == 1);

  state_t                  state_q;
  logic                    ready_q;
  logic [0:ARRAY_W_W-1][0:ARRAY_A_L-1][2*DATA_WIDTH-1:0] shadow_q;
  logic [ROW_BITS-1:0]     row_q;
  logic [COL_BITS-1:0]     col_q;
  logic [2*DATA_WIDTH-1:0] m_data_q;
  logic                    m_valid_q;
  logic                    m_last_q;
  logic                    busy_q;
  logic                    done_q;
  logic                    overrun_q;

  logic                    start_evt_s;
  logic                    hs_s;
  logic                    ovr_set_s;
  logic [ROW_BITS-1:0]     row_d;
  logic [COL_BITS-1:0]     col_d;
  logic                    last_d;

  // Rising-edge detect on fetch_ready and handshake / overrun qualifiers.
  always_comb begin
    start_evt_s = fetch_ready & ~ready_q;
    hs_s        = m_valid_q & m_if.m_ready;
    ovr_set_s   = start_evt_s & (state_q != S_IDLE);
  end

  // Next row-major position after the current element is accepted.
  always_comb begin
    row_d  = row_q;
    col_d  = col_q;
    last_d = 1'b0;
    if (col_q == COL_LAST) begin
      col_d = COL_ZERO;
      row_d = row_q + ROW_BITS'(1);
    end else begin
      col_d = col_q + COL_BITS'(1);
      row_d = row_q;
    end
    if ((row_d == ROW_LAST) && (col_d == COL_LAST)) begin
      last_d = 1'b1;
    end else begin
      last_d = 1'b0;
    end
  end

  // Previous-cycle copy of fetch_ready for edge detection.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ready_q <= 1'b0;
    end else begin
      ready_q <= fetch_ready;
    end
  end

  // Sticky overrun flag; a new result edge beats a same-cycle clear.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      overrun_q <= 1'b0;
    end else if (ovr_set_s) begin
      overrun_q <= 1'b1;
    end else if (clr_overrun) begin
      overrun_q <= 1'b0;
    end else begin
      overrun_q <= overrun_q;
    end
  end

  // Capture / stream / done sequencer with all stream outputs registered.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= S_IDLE;
      shadow_q  <= '0;
      row_q     <= ROW_ZERO;
      col_q     <= COL_ZERO;
      m_data_q  <= {(2*DATA_WIDTH){1'b0}};
      m_valid_q <= 1'b0;
      m_last_q  <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          done_q <= 1'b0;
          if (start_evt_s) begin
            // Snapshot taken on the same edge that sees the rising ready.
            shadow_q  <= fetch_data;
            row_q     <= ROW_ZERO;
            col_q     <= COL_ZERO;
            m_data_q  <= fetch_data[ROW_ZERO][COL_ZERO];
            m_last_q  <= SINGLE_ELEM;
            m_valid_q <= 1'b1;
            busy_q    <= 1'b1;
            state_q   <= S_STREAM;
          end
        end

        S_STREAM: begin
          // Without a handshake every stream output simply holds.
          if (hs_s) begin
            if (m_last_q) begin
              m_valid_q <= 1'b0;
              m_last_q  <= 1'b0;
              done_q    <= 1'b1;
              row_q     <= ROW_ZERO;
              col_q     <= COL_ZERO;
              state_q   <= S_DONE;
            end else begin
              row_q    <= row_d;
              col_q    <= col_d;
              m_data_q <= shadow_q[row_d][col_d];
              m_last_q <= last_d;
            end
          end
        end

        S_DONE: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end

        default: begin
          m_valid_q <= 1'b0;
          m_last_q  <= 1'b0;
          busy_q    <= 1'b0;
          done_q    <= 1'b0;
          state_q   <= S_IDLE;
        end
      endcase
    end
  end

  assign m_if.m_valid = m_valid_q;
  assign m_if.m_data  = m_data_q;
  assign m_if.m_row   = row_q;
  assign m_if.m_col   = col_q;
  assign m_if.m_last  = m_last_q;
  assign busy         = busy_q;
  assign done         = done_q;
  assign overrun      = overrun_q;

endmodule

// File: tb/tb_sys_array_result_streamer.sv
// Directed bench for sys_array_result_streamer: a table of drain scenarios
// plus hand-written sequences for overrun collision, reset abort and
// back-to-back results.
module tb_sys_array_result_streamer;

  localparam int DW = 8;
  localparam int W  = 5;
  localparam int L  = 15;
  localparam int RB = 3;
  localparam int CB = 4;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic fetch_ready = 1'b0;
  logic clr_overrun = 1'b0;
  logic [0:W-1][0:L-1][2*DW-1:0] fetch_data = '0;
  logic busy;
  logic done;
  logic overrun;

  sys_array_result_streamer_if m_if ();

  sys_array_result_streamer dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .fetch_ready (fetch_ready),
    .fetch_data  (fetch_data),
    .m_if        (m_if),
    .busy        (busy),
    .done        (done),
    .overrun     (overrun),
    .clr_overrun (clr_overrun)
  );

  always #5 clk = ~clk;

  int n_pass  = 0;
  int n_total = 0;

  typedef struct {
    string       name;
    logic [15:0] seed;
    logic [3:0]  pat;       // m_ready pattern, bit 0 used first
    int          iso_cyc;   // cycle to overwrite fetch_data with FFFF (0 = never)
    int          drop_cyc;  // cycle to drop fetch_ready (0 = never)
    int          raise_cyc; // cycle to re-raise fetch_ready (0 = never)
    int          exp_done;  // cycle (relative to raise) of the done pulse
    logic        exp_ov;    // overrun expected after done
  } vec_t;

  vec_t tbl [4];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  function automatic logic [15:0] elem(input logic [15:0] seed, input int i, input int j);
    return seed ^ (16'(i) * 16'h0100 + 16'(j));
  endfunction

  task automatic load(input logic [15:0] seed);
    for (int i = 0; i < W; i++)
      for (int j = 0; j < L; j++)
        fetch_data[3'(i)][4'(j)] = elem(seed, i, j);
  endtask

  function automatic logic [63:0] out_vec();
    return 64'({m_if.m_valid, m_if.m_data, m_if.m_row, m_if.m_col, m_if.m_last});
  endfunction

  // Caller raises fetch_ready at a negedge; cycle c counts negedges after it.
  task automatic drain(input string name, input logic [15:0] seed, input logic [3:0] pat,
                       input int iso_cyc, input int drop_cyc, input int raise_cyc,
                       output int beats, output int done_cyc);
    logic        hold;
    logic [63:0] hold_v;
    logic [63:0] exp_v;
    int          r;
    int          cc;
    beats = 0;
    done_cyc = -1;
    hold = 1'b0;
    hold_v = 64'd0;
    for (int c = 1; c <= 400; c++) begin
      @(negedge clk);
      if (c == 1) chk({name, "_latency"}, 64'(m_if.m_valid), 64'd1);
      if (hold) chk({name, "_hold"}, out_vec(), hold_v);
      if (raise_cyc > 0 && c == raise_cyc + 1) chk({name, "_ovr_set"}, 64'(overrun), 64'd1);
      if (done) begin
        done_cyc = c;
        break;
      end
      m_if.m_ready = pat[2'((c - 1) % 4)];
      if (iso_cyc == c) fetch_data = '1;
      if (drop_cyc == c) fetch_ready = 1'b0;
      if (raise_cyc == c) fetch_ready = 1'b1;
      if (m_if.m_valid && m_if.m_ready) begin
        r  = beats / L;
        cc = beats % L;
        exp_v = 64'({1'b1, elem(seed, r, cc), RB'(r), CB'(cc), (beats == W * L - 1)});
        chk({name, "_beat"}, out_vec(), exp_v);
        beats++;
      end
      hold = m_if.m_valid & ~m_if.m_ready;
      hold_v = out_vec();
    end
  endtask

  initial begin
    int   beats;
    int   dc;
    logic saw_done;

    tbl[0] = '{"basic",    16'h0000, 4'b1111, 0, 0,  0,  76,  1'b0};
    tbl[1] = '{"backpres", 16'h5A00, 4'b1001, 0, 0,  0,  150, 1'b0};
    tbl[2] = '{"isolate",  16'h1200, 4'b1111, 3, 0,  0,  76,  1'b0};
    tbl[3] = '{"overrun",  16'h3300, 4'b1111, 0, 10, 20, 76,  1'b1};

    m_if.m_ready = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_state",
        64'({m_if.m_valid, m_if.m_data, m_if.m_row, m_if.m_col, m_if.m_last, busy, done, overrun}),
        64'd0);
    reset_n = 1'b1;
    @(negedge clk);

    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      load(tbl[k].seed);
      fetch_ready = 1'b1;
      drain(tbl[k].name, tbl[k].seed, tbl[k].pat, tbl[k].iso_cyc, tbl[k].drop_cyc,
            tbl[k].raise_cyc, beats, dc);
      chk({tbl[k].name, "_beats"}, 64'(beats), 64'(W * L));
      chk({tbl[k].name, "_done_cyc"}, 64'(dc), 64'(tbl[k].exp_done));
      fetch_ready = 1'b0;
      @(negedge clk);
      chk({tbl[k].name, "_idle"}, 64'({m_if.m_valid, busy, done}), 64'd0);
      chk({tbl[k].name, "_ovr_final"}, 64'(overrun), 64'(tbl[k].exp_ov));
      if (tbl[k].exp_ov) begin
        clr_overrun = 1'b1;
        @(negedge clk);
        clr_overrun = 1'b0;
        chk({tbl[k].name, "_ovr_clr"}, 64'(overrun), 64'd0);
      end
    end

    // Overrun set and clear landing on the same edge: set must win.
    @(negedge clk);
    load(16'h7700);
    fetch_ready = 1'b1;
    m_if.m_ready = 1'b1;
    repeat (4) @(negedge clk);
    fetch_ready = 1'b0;
    repeat (2) @(negedge clk);
    fetch_ready = 1'b1;
    @(negedge clk);
    chk("collide_pre", 64'(overrun), 64'd1);
    fetch_ready = 1'b0;
    repeat (2) @(negedge clk);
    fetch_ready = 1'b1;
    clr_overrun = 1'b1;
    @(negedge clk);
    clr_overrun = 1'b0;
    chk("collide_set_wins", 64'(overrun), 64'd1);
    saw_done = 1'b0;
    for (int t = 0; t < 200; t++) begin
      @(negedge clk);
      if (done) begin
        saw_done = 1'b1;
        break;
      end
    end
    chk("collide_done_seen", 64'(saw_done), 64'd1);
    fetch_ready = 1'b0;
    clr_overrun = 1'b1;
    @(negedge clk);
    clr_overrun = 1'b0;
    chk("collide_clr", 64'(overrun), 64'd0);

    // Reset mid-stream: immediate abort, no done, then a fresh stream.
    @(negedge clk);
    load(16'h2400);
    fetch_ready = 1'b1;
    m_if.m_ready = 1'b1;
    repeat (20) @(negedge clk);
    chk("pre_rst_busy", 64'({m_if.m_valid, busy}), 64'd3);
    reset_n = 1'b0;
    #1;
    chk("rst_abort", 64'({m_if.m_valid, busy, done, m_if.m_row, m_if.m_col}), 64'd0);
    fetch_ready = 1'b0;
    saw_done = 1'b0;
    repeat (2) begin
      @(negedge clk);
      saw_done = saw_done | done | m_if.m_valid;
    end
    chk("rst_no_done", 64'(saw_done), 64'd0);
    reset_n = 1'b1;
    @(negedge clk);
    load(16'h4800);
    fetch_ready = 1'b1;
    drain("post_rst", 16'h4800, 4'b1111, 0, 0, 0, beats, dc);
    chk("post_rst_beats", 64'(beats), 64'(W * L));
    chk("post_rst_done_cyc", 64'(dc), 64'd76);

    // Back-to-back: new rising edge in the cycle right after done.
    fetch_ready = 1'b0;
    repeat (2) @(negedge clk);
    load(16'h0A00);
    fetch_ready = 1'b1;
    drain("b2b_a", 16'h0A00, 4'b1111, 0, 0, 0, beats, dc);
    chk("b2b_a_done_cyc", 64'(dc), 64'd76);
    fetch_ready = 1'b0;
    @(negedge clk);
    load(16'h0B00);
    fetch_ready = 1'b1;
    drain("b2b_b", 16'h0B00, 4'b1111, 0, 0, 0, beats, dc);
    chk("b2b_b_beats", 64'(beats), 64'(W * L));
    chk("b2b_b_done_cyc", 64'(dc), 64'd76);
    chk("b2b_no_overrun", 64'(overrun), 64'd0);
    fetch_ready = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/sys_array_result_streamer.md
Name: sys_array_result_streamer

Overview:
- Drain side of `sys_array_fetcher`.
- Detects each rising edge of the fetcher's `ready`, then snapshots the full parallel result matrix (`ARRAY_W_W` x `ARRAY_A_L` elements, each `2*DATA_WIDTH` wide) into a shadow register.
- Streams the snapshot out one element per handshake, row-major, over a valid/ready interface toward memory or a host link.
- Lets the fetcher start the next computation while results drain.

Parameters:
- DATA_WIDTH, 8, input operand width; each result element is 2*DATA_WIDTH bits.
- ARRAY_W_W, 5, result rows (weight matrix rows).
- ARRAY_A_L, 15, result columns (data matrix columns).
- ROW_BITS, $clog2(ARRAY_W_W) (min 1), row index width.
- COL_BITS, $clog2(ARRAY_A_L) (min 1), column index width.

Ports:
- clk  in  1  single clock, all logic rising-edge.
- reset_n  in  1  asynchronous, active-low reset.
- fetch_ready  in  1  fetcher `ready`; a result is complete when this rises.
- fetch_data  in  [0:ARRAY_W_W-1][0:ARRAY_A_L-1][2*DATA_WIDTH-1:0]  fetcher `out_data`.
- m_valid  out  1  stream element valid.
- m_ready  in  1  downstream accepts.
- m_data  out  2*DATA_WIDTH  current element.
- m_row  out  ROW_BITS  row index of m_data.
- m_col  out  COL_BITS  column index of m_data.
- m_last  out  1  high with the final element (row ARRAY_W_W-1, col ARRAY_A_L-1).
- busy  out  1  high while a snapshot is held or being streamed.
- done  out  1  one-cycle pulse after the last element is accepted.
- overrun  out  1  sticky; a new result arrived while busy.
- clr_overrun  in  1  synchronous clear of overrun.

Behaviour:
- Reset (reset_n=0, async): all outputs are 0, state=IDLE, row/col counters 0, shadow register 0, ready_q=0.
- Edge detection:
  - ready_q registers fetch_ready every cycle.
  - start_evt = fetch_ready & ~ready_q.
  - ready_q resets to 0, so fetch_ready high at reset release counts as an edge.
- State IDLE:
  - m_valid=0, busy=0.
  - On start_evt: load the shadow register from fetch_data at that same clock edge, clear row/col, go to STREAM.
  - First m_valid=1 appears the cycle after fetch_ready is first sampled high (latency 1).
- State STREAM:
  - m_valid=1, busy=1.
  - m_data=shadow[row][col], m_row=row, m_col=col.
  - m_last = (row==ARRAY_W_W-1 && col==ARRAY_A_L-1).
  - Handshake on m_valid&m_ready:
    - If col==ARRAY_A_L-1: col wraps to 0 and row increments.
    - Otherwise: col increments.
  - Without m_ready: m_data/m_row/m_col/m_last are held stable; valid is never withdrawn.
  - Handshake while m_last=1: go to DONE.
  - Throughput: one element per cycle when m_ready is held high. For defaults, 75 elements take 75 consecutive cycles.
- State DONE (1 cycle): done=1, m_valid=0, busy=1, then go to IDLE.
- start_evt in STREAM or DONE:
  - Snapshot is not reloaded; streaming continues unaffected.
  - overrun is set to 1 at the next edge.
- start_evt in the same cycle as the IDLE return:
  - Not possible to lose, because DONE→IDLE and IDLE samples start_evt.
  - An edge landing exactly in DONE counts as overrun.
- overrun:
  - Stays 1 until clr_overrun=1 (clear takes effect next edge).
  - If set and clear happen in the same cycle, set wins.
- fetch_data changes after capture: no effect on the stream.
- reset_n asserted mid-stream: abort immediately. m_valid drops asynchronously; no done pulse; state=IDLE.
- Arithmetic: counters saturate at no value; they only wrap as specified. Indices never exceed ARRAY_W_W-1 / ARRAY_A_L-1.

Test Plan:
- Basic drain:
  - Stimulus: load element [i][j] = 16'h0100*i + j, raise fetch_ready at cycle 10, hold m_ready=1.
  - Required: m_valid rises at cycle 11; 75 beats with m_data 0000,0001…000E,0100…040E; m_last only on beat 75 (row 4, col 14); done pulses at cycle 86; busy returns to 0 at cycle 87.
- Backpressure:
  - Stimulus: m_ready toggled 1,0,0,1 repeatedly.
  - Required: every element delivered exactly once, in order; outputs stable during m_ready=0; total 75 accepted beats; no overrun.
- Snapshot isolation:
  - Stimulus: change fetch_data to all FFFF at cycle 3 of streaming.
  - Required: streamed values still match the original snapshot.
- Overrun:
  - Stimulus: drop fetch_ready, then re-raise it mid-stream.
  - Required: overrun=1 next cycle, stream unchanged, overrun persists after done; clr_overrun=1 clears it.
  - Stimulus: simultaneous new rising edge and clr_overrun=1.
  - Required: overrun stays 1.
- Reset mid-stream:
  - Stimulus: assert reset_n=0 at beat 20 for 2 cycles, then raise fetch_ready again.
  - Required: m_valid=0, done never pulses, busy=0; a fresh stream starts from row 0, col 0.
- Back-to-back results:
  - Stimulus: second fetch_ready rising edge one cycle after done.
  - Required: new stream starts (state IDLE had sampled it), overrun stays 0, first beat is row 0, col 0 of the new data.
